// File: rtl/delay.sv
// Fixed-latency register delay line: data_out is data_in delayed by DEPTH clock edges.
// Each stage is its own flop instance so the chain stays a pure register path.

module delay_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else          q <= d;
  end

endmodule

module delay #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  if (DEPTH < 1 || DEPTH > 64 || WIDTH < 1) begin : g_bad_param
    $error("delay: DEPTH must be 1..64 and WIDTH >= 1");
  end

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] d;
    if (i == 0) begin : g_head
      assign d = data_in;
    end else begin : g_link
      assign d = stage[i-1];
    end
    delay_stage #(.WIDTH(WIDTH)) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (d),
      .q       (stage[i])
    );
  end

  // Output comes straight off the last flop; no combinational path from data_in.
  assign data_out = stage[DEPTH-1];

endmodule

// File: tb/tb_delay.sv
// Directed bench for the delay line: DEPTH=2 main instance plus DEPTH=1 and
// DEPTH=5/WIDTH=8 instances driven by a counter and checked against a sample history.

module tb_delay;

  logic        clock;
  logic        reset_n;
  logic [15:0] din2, dout2;
  logic [15:0] din1, dout1;
  logic [7:0]  din5, dout5;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [15:0] hist [$];

  delay #(.WIDTH(16), .DEPTH(2)) u_d2 (
    .clock(clock), .reset_n(reset_n), .data_in(din2), .data_out(dout2));
  delay #(.WIDTH(16), .DEPTH(1)) u_d1 (
    .clock(clock), .reset_n(reset_n), .data_in(din1), .data_out(dout1));
  delay #(.WIDTH(8), .DEPTH(5)) u_d5 (
    .clock(clock), .reset_n(reset_n), .data_in(din5), .data_out(dout5));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it before sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step2(input logic [15:0] v, input logic [15:0] exp, input string tag);
    din2 = v;
    tick();
    check(tag, dout2, exp);
  endtask

  function automatic logic [15:0] lag(input int d);
    if (hist.size() >= d) return hist[hist.size()-d];
    return 16'h0;
  endfunction

  initial begin
    reset_n = 1'b0;
    din2 = 16'hFFFF;
    din1 = 16'hFFFF;
    din5 = 8'hFF;

    // Reset held with all-ones input and clock running
    #1;
    check("rst_async_d2", dout2, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold_d2", dout2, 16'h0);
    end
    check("rst_hold_d1", dout1, 16'h0);
    check("rst_hold_d5", {8'h0, dout5}, 16'h0);

    // Release between edges; first sample takes DEPTH edges to show
    reset_n = 1'b1;
    step2(16'h0001, 16'h0000, "rel_edge1");
    step2(16'h0001, 16'h0001, "rel_edge2");

    // Incrementing stream from a clean reset
    reset_n = 1'b0; #2; reset_n = 1'b1;
    step2(16'h0001, 16'h0000, "inc_0");
    step2(16'h0002, 16'h0001, "inc_1");
    step2(16'h0003, 16'h0002, "inc_2");
    step2(16'h0004, 16'h0003, "inc_3");
    step2(16'h0004, 16'h0004, "inc_4");

    // Mid-stream reset discards in-flight words
    step2(16'h0010, 16'h0004, "mid_a");
    step2(16'h0011, 16'h0010, "mid_b");
    step2(16'h0012, 16'h0011, "mid_c");
    reset_n = 1'b0;
    #1;
    check("mid_async_clr", dout2, 16'h0);
    #1;
    reset_n = 1'b1;
    step2(16'h0020, 16'h0000, "mid_post0");
    step2(16'h0021, 16'h0020, "mid_post1");
    step2(16'h0022, 16'h0021, "mid_post2");

    // Full-range patterns
    step2(16'h0000, 16'h0022, "rng_0");
    step2(16'hFFFF, 16'h0000, "rng_1");
    step2(16'hA5A5, 16'hFFFF, "rng_2");
    step2(16'h5A5A, 16'hA5A5, "rng_3");
    step2(16'h0000, 16'h5A5A, "rng_4");

    // Hold constant for 10 cycles
    step2(16'h1234, 16'h0000, "hold_0");
    for (int i = 1; i < 10; i++) step2(16'h1234, 16'h1234, "hold_n");

    // Parameter sweep: counter into DEPTH=1 and DEPTH=5 instances
    reset_n = 1'b0; #2; reset_n = 1'b1;
    hist.delete();
    for (int i = 1; i <= 20; i++) begin
      din1 = 16'(i);
      din5 = 8'(i);
      tick();
      hist.push_back(16'(i));
      check("sweep_d1", dout1, lag(1));
      check("sweep_d5", {8'h0, dout5}, lag(5) & 16'h00FF);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
